// File: rtl/imem_boot_loader.sv
// UART boot loader: parses one framed image (length, payload, checksum), writes
// little-endian words into text_mem and releases the CPU reset only on a valid image.
module imem_boot_loader #(
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wren,
    output logic              cpu_rst_n,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int                 TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]   TMR_ONE  = TMR_W'(1);
    localparam logic [ADDR_W:0]    CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [16:0]        CAPACITY = 17'(1) << ADDR_W;

    state_t             state, next_state;
    logic [7:0]         len_lo;
    logic [7:0]         sum;
    logic [ADDR_W:0]    n_words;
    logic [23:0]        byte_buf;
    logic [1:0]         byte_idx;
    logic [TMR_W-1:0]   timer;
    logic [15:0]        len_rx;
    logic               byte_ok;
    logic               timed;
    logic               timeout;
    logic               last_word;
    logic               len_too_big;

    // A falling load_en always beats a coincident byte strobe.
    assign byte_ok     = rx_done && load_en;
    assign len_rx      = {rx_data, len_lo};
    assign len_too_big = {1'b0, len_rx} > CAPACITY;
    assign timed       = (state == LEN_HI) || (state == DATA) || (state == CSUM);
    assign timeout     = timed && !rx_done && (timer == TMR_LAST);
    assign last_word   = (byte_idx == 2'd3) && ((word_cnt + CNT_ONE) == n_words);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (load_en) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (!load_en)     next_state = ERR;
                else if (rx_done) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (!load_en || timeout) next_state = ERR;
                else if (rx_done) begin
                    if (len_too_big)        next_state = ERR;
                    else if (len_rx == '0)  next_state = CSUM;
                    else                    next_state = DATA;
                end
            end
            DATA: begin
                if (!load_en || timeout)       next_state = ERR;
                else if (rx_done && last_word) next_state = CSUM;
            end
            CSUM: begin
                if (!load_en || timeout) next_state = ERR;
                else if (rx_done)        next_state = (rx_data == sum) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (!load_en) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            cpu_rst_n <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_cnt  <= '0;
            len_lo    <= '0;
            sum       <= '0;
            n_words   <= '0;
            byte_buf  <= '0;
            byte_idx  <= '0;
            timer     <= '0;
        end else begin
            mem_wren <= 1'b0;

            if (timed && !rx_done) timer <= timer + TMR_ONE;
            else                   timer <= '0;

            if (state == IDLE && load_en) begin
                load_busy <= 1'b1;
                cpu_rst_n <= 1'b0;
                load_done <= 1'b0;
                load_err  <= 1'b0;
                word_cnt  <= '0;
                sum       <= '0;
                byte_idx  <= '0;
                byte_buf  <= '0;
            end

            if (state == LEN_LO && byte_ok) len_lo <= rx_data;
            if (state == LEN_HI && byte_ok) n_words <= len_rx[ADDR_W:0];

            if (state == DATA && byte_ok) begin
                sum      <= sum + rx_data;
                byte_idx <= byte_idx + 2'd1;
                byte_buf <= {rx_data, byte_buf[23:8]};
                if (byte_idx == 2'd3) begin
                    mem_wren  <= 1'b1;
                    mem_wdata <= {rx_data, byte_buf};
                    mem_waddr <= word_cnt[ADDR_W-1:0];
                    word_cnt  <= word_cnt + CNT_ONE;
                end
            end

            if (next_state == DONE && state != DONE) begin
                load_busy <= 1'b0;
                load_done <= 1'b1;
                cpu_rst_n <= 1'b1;
            end
            if (next_state == ERR && state != ERR) begin
                load_busy <= 1'b0;
                load_err  <= 1'b1;
                cpu_rst_n <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: expected text_mem writes are queued as
// bytes are driven and compared when the DUT pulses mem_wren.
module tb_imem_boot_loader;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 100;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_en;
    logic [7:0]        rx_data;
    logic              rx_done;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              mem_wren;
    logic              cpu_rst_n;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_count = 0;
    wr_t  exp_q[$];
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        m_sum;

    imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .cpu_rst_n (cpu_rst_n),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_wren === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {23'd0, mem_waddr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {23'd0, mem_waddr}, {23'd0, e.addr});
                check("wr_data", mem_wdata, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                exp_q.push_back('{addr: exp_addr, data: w});
                exp_addr = exp_addr + 1'b1;
            end
            m_sum = m_sum + w[8*i +: 8];
            send_byte(w[8*i +: 8]);
        end
        check("wren_latency", {31'd0, mem_wren}, 32'd1);
        @(negedge clk);
        check("wren_width", {31'd0, mem_wren}, 32'd0);
    endtask

    // Returns to IDLE (two low cycles cover an abort through ERR) and opens a new frame.
    task automatic start_frame();
        @(negedge clk);
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        check("start_busy", {31'd0, load_busy}, 32'd1);
        check("start_done_clr", {31'd0, load_done}, 32'd0);
        check("start_err_clr", {31'd0, load_err}, 32'd0);
        check("start_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
        check("start_word_cnt", {22'd0, word_cnt}, 32'd0);
        exp_addr = '0;
        m_sum    = '0;
    endtask

    task automatic frame_a(input logic [7:0] csum);
        send_hdr(16'd2);
        send_word(32'h0000_0013);
        send_word(32'h0000_006F);
        send_byte(csum);
    endtask

    initial begin
        int base;
        int cyc;
        rst_n    = 1'b0;
        load_en  = 1'b1;
        rx_data  = '0;
        rx_done  = 1'b0;
        exp_addr = '0;
        m_sum    = '0;

        // Reset with load_en already high.
        repeat (3) @(negedge clk);
        check("rst_outputs", {mem_wren, cpu_rst_n, load_busy, load_done, load_err,
                              word_cnt, mem_waddr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        check("rel_busy", {31'd0, load_busy}, 32'd0);
        @(negedge clk);
        check("len_lo_busy", {31'd0, load_busy}, 32'd1);

        // Good two-word frame.
        frame_a(8'h82);
        check("a_done", {31'd0, load_done}, 32'd1);
        check("a_cpu_rst", {31'd0, cpu_rst_n}, 32'd1);
        check("a_busy", {31'd0, load_busy}, 32'd0);
        check("a_word_cnt", {22'd0, word_cnt}, 32'd2);
        check("a_q_empty", exp_q.size(), 32'd0);

        // Same frame, bad checksum.
        start_frame();
        frame_a(8'h83);
        check("b_err", {31'd0, load_err}, 32'd1);
        check("b_done", {31'd0, load_done}, 32'd0);
        check("b_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
        check("b_word_cnt", {22'd0, word_cnt}, 32'd2);
        @(negedge clk);
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        check("b_idle_err_hold", {31'd0, load_err}, 32'd1);
        check("b_idle_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);

        // Oversized header: 513 words.
        start_frame();
        base = wr_count;
        send_hdr(16'h0201);
        check("big_err", {31'd0, load_err}, 32'd1);
        repeat (8) @(negedge clk);
        check("big_no_write", wr_count - base, 32'd0);

        // Exactly full capacity: 512 words, addresses 0..511.
        start_frame();
        send_hdr(16'h0200);
        check("cap_accepted", {31'd0, load_err}, 32'd0);
        for (int i = 0; i < 512; i++) begin
            logic [31:0] w;
            w = {8'(i) ^ 8'hA5, 8'(i >> 8), ~8'(i), 8'(i) + 8'h3C};
            send_word(w);
        end
        send_byte(m_sum);
        check("cap_done", {31'd0, load_done}, 32'd1);
        check("cap_word_cnt", {22'd0, word_cnt}, 32'd512);
        check("cap_q_empty", exp_q.size(), 32'd0);

        // Inter-byte timeout after two payload bytes.
        start_frame();
        base = wr_count;
        send_hdr(16'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        cyc = 0;
        while (load_err !== 1'b1 && cyc < 3 * TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        check("to_cycles", cyc, TIMEOUT);
        check("to_no_write", wr_count - base, 32'd0);
        check("to_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);

        // Abort coinciding with the 4th byte strobe: the byte must be dropped.
        start_frame();
        base = wr_count;
        send_hdr(16'd1);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        @(negedge clk);
        rx_data = 8'h77;
        rx_done = 1'b1;
        load_en = 1'b0;
        @(negedge clk);
        rx_done = 1'b0;
        check("abort_err", {31'd0, load_err}, 32'd1);
        check("abort_wren", {31'd0, mem_wren}, 32'd0);
        check("abort_word_cnt", {22'd0, word_cnt}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_write", wr_count - base, 32'd0);

        // Empty image, then a full frame after toggling load_en.
        start_frame();
        base = wr_count;
        send_hdr(16'd0);
        send_byte(8'h00);
        check("empty_done", {31'd0, load_done}, 32'd1);
        check("empty_word_cnt", {22'd0, word_cnt}, 32'd0);
        check("empty_no_write", wr_count - base, 32'd0);
        start_frame();
        frame_a(8'h82);
        check("again_done", {31'd0, load_done}, 32'd1);
        check("again_cpu_rst", {31'd0, cpu_rst_n}, 32'd1);
        check("again_word_cnt", {22'd0, word_cnt}, 32'd2);

        // Reset mid-frame returns everything to zero.
        start_frame();
        send_hdr(16'd1);
        send_byte(8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {mem_wren, cpu_rst_n, load_busy, load_done, load_err,
                                 word_cnt, mem_waddr}, 32'd0);
        check("final_q_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences program download into the CPU instruction memory (text_mem) over UART before the core runs.
- Consumes bytes from rx_controller (RX_DATA/RX_DONE) and parses one framed image: length header, payload, checksum.
- Assembles little-endian 32-bit words and drives the text_mem write port.
- Holds the CPU in reset until a complete, checksum-valid image has been written.

Parameters:
- ADDR_W, 9, text_mem word-address width; capacity 2^ADDR_W words.
- TIMEOUT_CYC, 5000000, maximum clk cycles between bytes once a frame has started (100 ms at 50 MHz).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  synchronous active-low reset
- load_en  in  1  load-mode enable (SW[17] level)
- rx_data  in  8  received UART byte, valid when rx_done=1
- rx_done  in  1  single-cycle byte strobe from rx_controller
- mem_waddr  out  ADDR_W  text_mem word write address
- mem_wdata  out  32  text_mem write data
- mem_wren  out  1  text_mem write enable, one cycle per word
- cpu_rst_n  out  1  CPU reset, active-low
- load_busy  out  1  frame in progress
- load_done  out  1  last frame completed successfully
- load_err  out  1  last frame aborted
- word_cnt  out  ADDR_W+1  words written in current/last frame

Behaviour:
- Reset is synchronous. While rst_n=0 the block is held in reset: state=IDLE, all outputs 0 (cpu_rst_n=0), counters and byte buffers cleared.
- Frame format:
  - LEN_LO, LEN_HI: N = word count, little-endian 16-bit.
  - 4*N payload bytes, LSB first per word.
  - CSUM: 8-bit modulo-256 sum of payload bytes only.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE:
  - load_en=1 -> LEN_LO next cycle.
  - On entry to LEN_LO: load_busy=1, cpu_rst_n=0, load_done=0, load_err=0, word_cnt=0, sum=0.
  - rx_done in IDLE is ignored.
- LEN_LO: waits indefinitely (no timeout). rx_done latches the low byte -> LEN_HI.
- LEN_HI: rx_done latches the high byte, then branches:
  - N > 2^ADDR_W -> ERR.
  - N = 0 -> CSUM.
  - Otherwise -> DATA.
- DATA:
  - Each rx_done shifts the byte into a 24-bit buffer and adds it to sum; byte index counts 0..3.
  - On the 4th byte, the cycle after its rx_done:
    - mem_wren=1 for exactly one cycle;
    - mem_wdata = {byte3, byte2, byte1, byte0};
    - mem_waddr = word_cnt[ADDR_W-1:0];
    - word_cnt increments in the same cycle.
  - After word N is written -> CSUM.
- CSUM: rx_done compares rx_data with sum.
  - Equal -> DONE.
  - Not equal -> ERR.
  - The compare uses the sum including all payload bytes.
- DONE: load_busy=0, load_done=1, cpu_rst_n=1.
- ERR: load_busy=0, load_err=1, cpu_rst_n=0.
- Exit from DONE/ERR: -> IDLE when load_en=0. Flags and cpu_rst_n hold their values in IDLE until the next frame starts.
- Timeout: a cycle counter runs in LEN_HI, DATA and CSUM and clears on every rx_done. Reaching TIMEOUT_CYC-1 without a byte -> ERR.
- Abort: load_en=0 in LEN_LO..CSUM -> ERR next cycle. Words already written stay in memory; cpu_rst_n stays 0.
- Simultaneous events: load_en falling and rx_done in the same cycle -> abort wins and the byte is discarded.
- rx_done while mem_wren is high: accepted normally, since byte spacing far exceeds one cycle. The buffer must not be corrupted by back-to-back strobes.
- mem_waddr never wraps; the capacity check in LEN_HI guarantees word_cnt <= 2^ADDR_W.
- rst_n low mid-frame: immediate return to reset values. The partial image is not invalidated in memory, but cpu_rst_n=0.

Test Plan:
- Reset with load_en=1 -> after release all outputs 0; LEN_LO entered one cycle later; load_busy=1.
- Frame 02 00, 13 00 00 00, 6F 00 00 00, checksum 0x82 -> two writes: addr0 = 0x00000013, addr1 = 0x0000006F.
  - Each mem_wren is 1 cycle wide, one cycle after the 4th byte strobe.
  - Then load_done=1, cpu_rst_n=1, word_cnt=2.
- Same frame with checksum 0x83 -> both words written, then ERR: load_err=1, cpu_rst_n=0.
  - Drop load_en -> IDLE; flags hold.
- Header 01 02 (N=513, ADDR_W=9) -> ERR right after LEN_HI, with no mem_wren ever.
  - Header 00 02 (N=512) is accepted.
- Header 01 00, then 2 payload bytes, then silence (TIMEOUT_CYC=100 in bench) -> ERR exactly 100 cycles after the last rx_done, with no write.
  - Repeat with load_en dropped mid-word and rx_done in the same cycle -> ERR; the byte is not counted.
- Header 00 00, checksum 00 -> DONE with word_cnt=0 and no writes.
  - Then a second full frame after toggling load_en -> load_done cleared at frame start and set again at its end.
